// File: rtl/cve2_mem_arbiter_pkg.sv
// Shared types and the arbitration pick rule for the instruction/data
// memory port arbiter.
package cve2_mem_arbiter_pkg;

    typedef enum logic {
        SrcInstr = 1'b0,
        SrcData  = 1'b1
    } mem_src_e;

    typedef enum logic {
        ArbIdle = 1'b0,
        ArbHold = 1'b1
    } arb_state_e;

    // Fixed priority favours data; round-robin favours whoever was not granted last.
    function automatic mem_src_e arb_pick(
        input logic     instr_req,
        input logic     data_req,
        input logic     fixed_prio,
        input mem_src_e last_src
    );
        mem_src_e pick;
        if (instr_req && data_req) begin
            if (fixed_prio) begin
                pick = SrcData;
            end else begin
                pick = (last_src == SrcData) ? SrcInstr : SrcData;
            end
        end else if (data_req) begin
            pick = SrcData;
        end else begin
            pick = SrcInstr;
        end
        return pick;
    endfunction

endpackage

// File: rtl/cve2_arb_resp_fifo.sv
// In-order FIFO of request source IDs; the head tells the arbiter where the
// next memory response belongs. A push is accepted while full if a pop coincides.
module cve2_arb_resp_fifo
    import cve2_mem_arbiter_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  logic data_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output logic head_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    mem_src_e          mem_q [Depth];
    logic [PtrW-1:0]   wptr_q;
    logic [PtrW-1:0]   rptr_q;
    logic [CntW-1:0]   cnt_q;
    logic              push_en;
    logic              pop_en;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? {PtrW{1'b0}} : ptr + PtrW'(1);
    endfunction

    assign empty_o = (cnt_q == {CntW{1'b0}});
    assign full_o  = (cnt_q == CntW'(Depth));
    assign pop_en  = pop_i & ~empty_o;
    assign push_en = push_i & (~full_o | pop_en);
    assign head_o  = mem_q[rptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= SrcInstr;
            end
            wptr_q <= {PtrW{1'b0}};
            rptr_q <= {PtrW{1'b0}};
            cnt_q  <= {CntW{1'b0}};
        end else begin
            if (push_en) begin
                mem_q[wptr_q] <= mem_src_e'(data_i);
                wptr_q        <= ptr_inc(wptr_q);
            end
            if (pop_en) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            case ({push_en, pop_en})
                2'b10:   cnt_q <= cnt_q + CntW'(1);
                2'b01:   cnt_q <= cnt_q - CntW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/cve2_mem_arbiter.sv
// Shares one OBI-style memory port between instruction fetch and the LSU,
// holding the presented request stable until granted and routing responses in order.
module cve2_mem_arbiter
    import cve2_mem_arbiter_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2,
    parameter logic        DataPriority   = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic        mem_err_i,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    output logic        proto_err_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    arb_state_e      state_q;
    mem_src_e        held_q;
    mem_src_e        last_q;
    logic [CntW-1:0] count_q;
    logic [CntW-1:0] count_d;
    logic            proto_err_q;

    mem_src_e        pick_s;
    mem_src_e        cur_src_s;
    mem_src_e        rsp_src_s;
    logic            src_req_s;
    logic            can_issue_s;
    logic            req_s;
    logic            handshake_s;
    logic            rsp_pop_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic            fifo_head_s;

    assign pick_s      = arb_pick(instr_req_i, data_req_i, DataPriority, last_q);
    assign cur_src_s   = (state_q == ArbHold) ? held_q : pick_s;
    assign src_req_s   = (state_q == ArbHold) | instr_req_i | data_req_i;
    assign rsp_pop_s   = mem_rvalid_i & ~fifo_empty_s;
    // A response retiring this cycle frees its slot for a same-cycle grant.
    assign can_issue_s = ((count_q < CntW'(MaxOutstanding)) & ~fifo_full_s) | rsp_pop_s;
    assign req_s       = src_req_s & can_issue_s;
    assign handshake_s = req_s & mem_gnt_i;
    assign rsp_src_s   = mem_src_e'(fifo_head_s);

    cve2_arb_resp_fifo #(
        .Depth (MaxOutstanding)
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (handshake_s),
        .data_i  (cur_src_s),
        .pop_i   (mem_rvalid_i),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .head_o  (fifo_head_s)
    );

    always_comb begin
        case ({handshake_s, rsp_pop_s})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        mem_req_o      = req_s;
        mem_we_o       = 1'b0;
        mem_be_o       = 4'h0;
        mem_addr_o     = 32'h0;
        mem_wdata_o    = 32'h0;
        instr_gnt_o    = handshake_s & (cur_src_s == SrcInstr);
        data_gnt_o     = handshake_s & (cur_src_s == SrcData);
        instr_rvalid_o = rsp_pop_s & (rsp_src_s == SrcInstr);
        data_rvalid_o  = rsp_pop_s & (rsp_src_s == SrcData);
        instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : 32'h0;
        data_rdata_o   = data_rvalid_o ? mem_rdata_i : 32'h0;
        instr_err_o    = instr_rvalid_o & mem_err_i;
        data_err_o     = data_rvalid_o & mem_err_i;
        proto_err_o    = proto_err_q;
        if (req_s && (cur_src_s == SrcData)) begin
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
        end else if (req_s) begin
            mem_be_o    = 4'hF;
            mem_addr_o  = instr_addr_i;
        end else begin
            mem_addr_o  = 32'h0;
        end
    end

    // Ungranted requests park in HOLD so the presented source cannot change.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ArbIdle;
            held_q  <= SrcInstr;
        end else begin
            case (state_q)
                ArbIdle: begin
                    if (req_s && !mem_gnt_i) begin
                        state_q <= ArbHold;
                        held_q  <= cur_src_s;
                    end
                end
                ArbHold: begin
                    if (mem_gnt_i) begin
                        state_q <= ArbIdle;
                    end
                end
                default: state_q <= ArbIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q      <= SrcData;
            count_q     <= {CntW{1'b0}};
            proto_err_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (handshake_s) begin
                last_q <= cur_src_s;
            end
            if (mem_rvalid_i && fifo_empty_s) begin
                proto_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cve2_mem_arbiter.sv
// Directed bench for cve2_mem_arbiter: a fixed-priority and a round-robin
// instance share stimulus; expected response owners are queued at each grant.
module tb_cve2_mem_arbiter;
    import cve2_mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        instr_req, data_req, data_we, mem_gnt, mem_rvalid, mem_err;
    logic [3:0]  data_be;
    logic [31:0] instr_addr, data_addr, data_wdata, mem_rdata;

    logic        m_igreally, m_ignt, m_irv, m_ierr, m_dgnt, m_drv, m_derr, m_req, m_we, m_perr;
    logic [31:0] m_ird, m_drd, m_addr, m_wdata;
    logic [3:0]  m_be;
    logic        r_ignt, r_irv, r_ierr, r_dgnt, r_drv, r_derr, r_req, r_we, r_perr;
    logic [31:0] r_ird, r_drd, r_addr, r_wdata;
    logic [3:0]  r_be;

    int tests = 0;
    int fails = 0;
    mem_src_e q_main[$];
    mem_src_e q_rr[$];

    always #5 clk = ~clk;

    cve2_mem_arbiter u_dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .instr_req_i(instr_req), .instr_gnt_o(m_ignt), .instr_rvalid_o(m_irv),
        .instr_addr_i(instr_addr), .instr_rdata_o(m_ird), .instr_err_o(m_ierr),
        .data_req_i(data_req), .data_gnt_o(m_dgnt), .data_rvalid_o(m_drv),
        .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata), .data_rdata_o(m_drd), .data_err_o(m_derr),
        .mem_req_o(m_req), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_err_i(mem_err),
        .mem_we_o(m_we), .mem_be_o(m_be), .mem_addr_o(m_addr), .mem_wdata_o(m_wdata),
        .mem_rdata_i(mem_rdata), .proto_err_o(m_perr)
    );

    cve2_mem_arbiter #(.MaxOutstanding(2), .DataPriority(1'b0)) u_rr (
        .clk_i(clk), .rst_ni(rst_ni),
        .instr_req_i(instr_req), .instr_gnt_o(r_ignt), .instr_rvalid_o(r_irv),
        .instr_addr_i(instr_addr), .instr_rdata_o(r_ird), .instr_err_o(r_ierr),
        .data_req_i(data_req), .data_gnt_o(r_dgnt), .data_rvalid_o(r_drv),
        .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata), .data_rdata_o(r_drd), .data_err_o(r_derr),
        .mem_req_o(r_req), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_err_i(mem_err),
        .mem_we_o(r_we), .mem_be_o(r_be), .mem_addr_o(r_addr), .mem_wdata_o(r_wdata),
        .mem_rdata_i(mem_rdata), .proto_err_o(r_perr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instr_req = 1'b0; data_req = 1'b0; data_we = 1'b0; data_be = 4'h0;
        instr_addr = 32'h0; data_addr = 32'h0; data_wdata = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        q_main.delete();
        q_rr.delete();
        step();
        step();
        rst_ni = 1'b1;
        step();
    endtask

    // Checks grant routing and address for one instance, then queues the expected response owner.
    task automatic grant_chk(input string tag, input bit rr, input mem_src_e s, input logic [31:0] addr);
        chk({tag, ".req"},   rr ? r_req  : m_req,  32'h1);
        chk({tag, ".addr"},  rr ? r_addr : m_addr, addr);
        chk({tag, ".ignt"},  rr ? r_ignt : m_ignt, {31'h0, s == SrcInstr});
        chk({tag, ".dgnt"},  rr ? r_dgnt : m_dgnt, {31'h0, s == SrcData});
        if (rr) q_rr.push_back(s);
        else    q_main.push_back(s);
    endtask

    task automatic grant_both(input string tag, input mem_src_e s, input logic [31:0] addr);
        grant_chk({tag, ".m"}, 1'b0, s, addr);
        grant_chk({tag, ".r"}, 1'b1, s, addr);
    endtask

    task automatic chk_rsp(input string tag, input bit rr, input logic [31:0] rd, input logic er);
        mem_src_e s;
        tests++;
        if ((rr ? q_rr.size() : q_main.size()) == 0) begin
            fails++;
            $error("FAIL %s.sb: observed empty scoreboard expected an entry", tag);
            return;
        end
        s = rr ? q_rr.pop_front() : q_main.pop_front();
        chk({tag, ".irv"},  rr ? r_irv  : m_irv,  {31'h0, s == SrcInstr});
        chk({tag, ".drv"},  rr ? r_drv  : m_drv,  {31'h0, s == SrcData});
        chk({tag, ".ird"},  rr ? r_ird  : m_ird,  (s == SrcInstr) ? rd : 32'h0);
        chk({tag, ".drd"},  rr ? r_drd  : m_drd,  (s == SrcData) ? rd : 32'h0);
        chk({tag, ".ierr"}, rr ? r_ierr : m_ierr, {31'h0, (s == SrcInstr) & er});
        chk({tag, ".derr"}, rr ? r_derr : m_derr, {31'h0, (s == SrcData) & er});
    endtask

    task automatic rsp_both(input string tag, input logic [31:0] rd, input logic er);
        chk_rsp({tag, ".m"}, 1'b0, rd, er);
        chk_rsp({tag, ".r"}, 1'b1, rd, er);
    endtask

    initial begin
        idle_inputs();
        rst_ni = 1'b0;
        #3;
        chk("rst.req",  m_req,  32'h0);
        chk("rst.ignt", m_ignt, 32'h0);
        chk("rst.dgnt", m_dgnt, 32'h0);
        chk("rst.irv",  m_irv,  32'h0);
        chk("rst.drv",  m_drv,  32'h0);
        chk("rst.perr", m_perr, 32'h0);
        chk("rst.addr", m_addr, 32'h0);
        do_reset();

        // Single instruction fetch, immediate grant, response next cycle.
        instr_req = 1'b1; instr_addr = 32'h80; mem_gnt = 1'b1; #1;
        grant_both("t1.g", SrcInstr, 32'h80);
        chk("t1.be", m_be, 32'hF);
        step();
        instr_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013; #1;
        rsp_both("t1.r", 32'h0000_0013, 1'b0);
        step();
        mem_rvalid = 1'b0;
        chk("t1.cnt", u_dut.count_q, 32'h0);

        // Consecutive ties: fixed priority always data, round-robin alternates from instr.
        do_reset();
        instr_req = 1'b1; instr_addr = 32'h200; data_req = 1'b1; data_addr = 32'h300; mem_gnt = 1'b1; #1;
        grant_chk("t2.a.m", 1'b0, SrcData, 32'h300);
        grant_chk("t2.a.r", 1'b1, SrcInstr, 32'h200);
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'hA1; #1;
        rsp_both("t2.b", 32'hA1, 1'b0);
        grant_chk("t2.b.m", 1'b0, SrcData, 32'h300);
        grant_chk("t2.b.r", 1'b1, SrcData, 32'h300);
        step();
        mem_rdata = 32'hA2; #1;
        rsp_both("t2.c", 32'hA2, 1'b0);
        grant_chk("t2.c.m", 1'b0, SrcData, 32'h300);
        grant_chk("t2.c.r", 1'b1, SrcInstr, 32'h200);
        step();
        instr_req = 1'b0; data_req = 1'b0; mem_gnt = 1'b0; mem_rdata = 32'hA3; #1;
        rsp_both("t2.d", 32'hA3, 1'b0);
        step();
        mem_rvalid = 1'b0;
        chk("t2.cnt.m", u_dut.count_q, 32'h0);
        chk("t2.cnt.r", u_rr.count_q, 32'h0);

        // Data request held three cycles while instr arrives; selection must not move.
        do_reset();
        data_req = 1'b1; data_addr = 32'hD000_0010; data_we = 1'b1; data_be = 4'h3; data_wdata = 32'hCAFE; #1;
        chk("t3.h0.req",  m_req,  32'h1);
        chk("t3.h0.addr", m_addr, 32'hD000_0010);
        chk("t3.h0.dgnt", m_dgnt, 32'h0);
        step();
        instr_req = 1'b1; instr_addr = 32'h100;
        for (int i = 1; i < 3; i++) begin
            #1;
            chk("t3.h.addr.m",  m_addr,  32'hD000_0010);
            chk("t3.h.addr.r",  r_addr,  32'hD000_0010);
            chk("t3.h.wdata",   m_wdata, 32'hCAFE);
            chk("t3.h.ignt.m",  m_ignt,  32'h0);
            chk("t3.h.ignt.r",  r_ignt,  32'h0);
            step();
        end
        mem_gnt = 1'b1; #1;
        grant_both("t3.gd", SrcData, 32'hD000_0010);
        chk("t3.we", m_we, 32'h1);
        chk("t3.be", m_be, 32'h3);
        step();
        data_req = 1'b0; #1;
        grant_both("t3.gi", SrcInstr, 32'h100);
        step();
        instr_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55; #1;
        rsp_both("t3.r1", 32'h55, 1'b0);
        step();
        mem_rdata = 32'h66; #1;
        rsp_both("t3.r2", 32'h66, 1'b0);
        step();
        mem_rvalid = 1'b0;

        // Outstanding limit of two, then a retiring response frees a slot the same cycle.
        do_reset();
        instr_req = 1'b1; instr_addr = 32'h400; mem_gnt = 1'b1; #1;
        grant_both("t4.g1", SrcInstr, 32'h400);
        step();
        instr_addr = 32'h404; #1;
        grant_both("t4.g2", SrcInstr, 32'h404);
        step();
        instr_addr = 32'h408; #1;
        chk("t4.full.req",  m_req,  32'h0);
        chk("t4.full.ignt", m_ignt, 32'h0);
        chk("t4.full.rreq", r_req,  32'h0);
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'hB1; #1;
        rsp_both("t4.r1", 32'hB1, 1'b0);
        grant_both("t4.g3", SrcInstr, 32'h408);
        step();
        instr_req = 1'b0; mem_gnt = 1'b0; mem_rdata = 32'hB2; #1;
        rsp_both("t4.r2", 32'hB2, 1'b0);
        step();
        mem_rdata = 32'hB3; #1;
        rsp_both("t4.r3", 32'hB3, 1'b0);
        step();
        mem_rvalid = 1'b0;
        chk("t4.cnt", u_dut.count_q, 32'h0);

        // Interleaved owners, error on the second response only.
        instr_req = 1'b1; instr_addr = 32'h500; mem_gnt = 1'b1; #1;
        grant_both("t5.gi", SrcInstr, 32'h500);
        step();
        instr_req = 1'b0; data_req = 1'b1; data_addr = 32'h600; data_we = 1'b0; #1;
        grant_both("t5.gd", SrcData, 32'h600);
        step();
        data_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111; #1;
        rsp_both("t5.r1", 32'h1111, 1'b0);
        step();
        mem_rdata = 32'h2222; mem_err = 1'b1; #1;
        rsp_both("t5.r2", 32'h2222, 1'b1);
        step();
        mem_rvalid = 1'b0; mem_err = 1'b0;
        chk("t5.perr0", m_perr, 32'h0);

        // Spurious response: dropped, sticky flag until reset.
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD; #1;
        chk("t6.irv", m_irv, 32'h0);
        chk("t6.drv", m_drv, 32'h0);
        chk("t6.ird", m_ird, 32'h0);
        step();
        mem_rvalid = 1'b0; #1;
        chk("t6.perr.m", m_perr, 32'h1);
        chk("t6.perr.r", r_perr, 32'h1);
        step(); step(); step();
        chk("t6.sticky", m_perr, 32'h1);
        do_reset();
        chk("t6.clr", m_perr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
